button_event_decoder: RTL and testbench
=======================================

# button_event_decoder

Classifies a debounced, active-low push-button into single-cycle events: press, release, short click, long press and double click. Sits directly downstream of the synchronizer/debouncer pair and feeds exercise logic (LED controllers, counters) that needs semantic button events instead of a raw level. All outputs are registered pulses or levels in the single clock domain.

## Interface
- LONG_CYC, 25_000_000: cycles the button must stay pressed to qualify as a long press (≥2).
- GAP_CYC, 12_500_000: maximum released interval, in cycles, between two clicks for a double click (≥2).
- CNT_W, 26: counter width; LONG_CYC and GAP_CYC must be < 2**CNT_W.
- clk_i  in  1  system clock; one clock domain, all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- btn_n_i  in  1  debounced button level, 0 = pressed.
- press_o  out  1  one-cycle pulse on each accepted press edge.
- release_o  out  1  one-cycle pulse on release of an accepted press.
- short_o  out  1  one-cycle pulse: single click confirmed.
- long_o  out  1  one-cycle pulse: long-press threshold reached.
- double_o  out  1  one-cycle pulse: second click started within the gap.
- held_o  out  1  level, high while in LONG state.

## Operation
- One input register btn_q (previous level). Press edge = btn_q & ~btn_n_i; release edge = ~btn_q & btn_n_i.
- One counter cnt[CNT_W-1:0], cleared on every state change.
- FSM states: IDLE, PRESS1, LONG, GAP, PRESS2.
- IDLE: press edge -> PRESS1, press_o. Release edges ignored.
- PRESS1: btn_n_i=0 and cnt==LONG_CYC-1 -> LONG, long_o; btn_n_i=0 otherwise -> cnt+1; btn_n_i=1 -> GAP, release_o.
- LONG: held_o=1; btn_n_i=1 -> IDLE, release_o. No short_o for a long press.
- GAP: btn_n_i=0 -> PRESS2, press_o and double_o in the same cycle; btn_n_i=1 and cnt==GAP_CYC-1 -> IDLE, short_o; else cnt+1.
- PRESS2: waits for release, no counting, no long_o; btn_n_i=1 -> IDLE, release_o.
- Simultaneous events: release at the long threshold edge -> release wins (GAP, no long_o). Press at the gap timeout edge -> press wins (double_o, no short_o).
- Counter never wraps: it is compared and cleared before reaching LONG_CYC/GAP_CYC.
- Only one of short_o, long_o, double_o may be high in a cycle; at most one classification per click sequence.

## Timing
- Reset: state IDLE, cnt 0, all outputs 0, btn_q=0 (treated as pressed). A button held through reset generates no events until released and pressed again; that release produces no release_o.
- Reset mid-operation: any state returns to IDLE next edge; pending short/long/double are dropped.
- Latency: press_o high in the cycle after the first clock edge sampling btn_n_i=0 (edge k).
- long_o high exactly LONG_CYC cycles after press_o if held throughout.
- release_o high in the cycle after the first edge sampling btn_n_i=1.
- short_o high exactly GAP_CYC cycles after release_o if no new press.
- All pulses are exactly one cycle wide; held_o rises with long_o and falls with release_o.

## Test plan
- Reset: assert rst_i 3 cycles with btn_n_i=1 -> all outputs 0, held_o 0; hold btn_n_i=0 through reset, release, wait 20 cycles -> no pulses at all.
- Short click (LONG_CYC=8, GAP_CYC=5): press 3 cycles, release -> press_o, release_o 3 cycles later, short_o 5 cycles after release_o; no long_o/double_o.
- Long press: hold 20 cycles -> long_o 8 cycles after press_o, held_o high from then until release_o; no short_o after release.
- Double click: press 2, release 2, press 20 -> press_o+double_o together on second press, no long_o, release_o on second release, no short_o.
- Boundaries: release on the 8th held cycle -> no long_o, short_o follows; press exactly on the 5th gap cycle -> double_o, no short_o.
- Mid-operation reset: rst_i during GAP -> no short_o ever issued; next press gives normal press_o.

Source files
------------

// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a debounced, active-low push-button level into single-cycle semantic
// events: press, release, short click, long press and double click, plus a
// held level while a long press is in progress. Every output is registered.

module button_event_decoder #(
  parameter int LONG_CYC = 25_000_000,
  parameter int GAP_CYC  = 12_500_000,
  parameter int CNT_W    = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic held_o
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_LONG   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_PRESS2 = 3'd4;

  // Terminal counts: the counter is compared against the last value and the
  // transition clears it, so it never reaches LONG_CYC/GAP_CYC and never wraps.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             btn_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             held_q, held_d;
  logic             press_edge;

  // btn_q resets to 0 ("pressed"), so a button held through reset cannot
  // produce a press edge until it has been released and pressed again.
  assign press_edge = btn_q & ~btn_n_i;

  // Next-state, counter and event decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Release edges are ignored here; only a fresh press starts a sequence.
        if (press_edge) begin
          state_d = ST_PRESS1;
          press_d = 1'b1;
        end
      end

      ST_PRESS1: begin
        // Release is checked first so a release on the threshold edge wins.
        if (btn_n_i) begin
          state_d   = ST_GAP;
          release_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_LONG: begin
        // A long press is already classified; its release gives no short click.
        if (btn_n_i) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end
      end

      ST_GAP: begin
        // Press is checked first so a press on the timeout edge wins.
        if (!btn_n_i) begin
          state_d  = ST_PRESS2;
          press_d  = 1'b1;
          double_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_PRESS2: begin
        // Second click is already classified as a double; just wait for release.
        if (btn_n_i) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every state change restarts the counter.
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    held_d = (state_d == ST_LONG);
  end

  // State, counter, input history and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_q     <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      btn_q     <= btn_n_i;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      double_q  <= double_d;
      held_q    <= held_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign short_o   = short_q;
  assign long_o    = long_q;
  assign double_o  = double_q;
  assign held_o    = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed testbench for button_event_decoder with LONG_CYC=8, GAP_CYC=5.
// Each tick drives btn_n_i, clocks once, samples outputs 1 ns after the edge
// and records how often and in which cycle each output was high.

module tb_button_event_decoder;

  logic clk_i = 1'b0;
  logic rst_i;
  logic btn_n_i;
  logic press_o, release_o, short_o, long_o, double_o, held_o;

  button_event_decoder #(
    .LONG_CYC(8),
    .GAP_CYC (5),
    .CNT_W   (8)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .btn_n_i  (btn_n_i),
    .press_o  (press_o),
    .release_o(release_o),
    .short_o  (short_o),
    .long_o   (long_o),
    .double_o (double_o),
    .held_o   (held_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Per-scenario observation record
  int cyc;
  int n_press, n_rel, n_short, n_long, n_dbl, n_held, n_multi;
  int t_press, t_rel, t_short, t_long, t_dbl, t_held_first, t_held_last;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic clr();
    cyc = 0;
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_dbl = 0; n_held = 0; n_multi = 0;
    t_press = -1; t_rel = -1; t_short = -1; t_long = -1; t_dbl = -1;
    t_held_first = -1; t_held_last = -1;
  endtask

  task automatic tick(input logic b);
    btn_n_i = b;
    @(posedge clk_i);
    #1;
    cyc++;
    if (press_o)   begin n_press++; t_press = cyc; end
    if (release_o) begin n_rel++;   t_rel   = cyc; end
    if (short_o)   begin n_short++; t_short = cyc; end
    if (long_o)    begin n_long++;  t_long  = cyc; end
    if (double_o)  begin n_dbl++;   t_dbl   = cyc; end
    if (held_o) begin
      n_held++;
      if (t_held_first < 0) t_held_first = cyc;
      t_held_last = cyc;
    end
    if ((int'(short_o) + int'(long_o) + int'(double_o)) > 1) n_multi++;
  endtask

  task automatic ticks(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  initial begin
    rst_i   = 1'b1;
    btn_n_i = 1'b1;
    clr();

    // Reset with button released: everything quiet
    ticks(1'b1, 3);
    check("rst_outputs", int'({press_o, release_o, short_o, long_o, double_o}), 0);
    check("rst_held", int'(held_o), 0);
    rst_i = 1'b0;
    ticks(1'b1, 3);

    // Button held through reset, then released: no events at all
    clr();
    rst_i = 1'b1;
    ticks(1'b0, 3);
    rst_i = 1'b0;
    ticks(1'b0, 3);
    ticks(1'b1, 20);
    check("held_rst_pulses", n_press + n_rel + n_short + n_long + n_dbl + n_held, 0);

    // Short click: press 3 cycles, release
    clr();
    ticks(1'b0, 3);
    ticks(1'b1, 10);
    check("short_n_press", n_press, 1);
    check("short_t_press", t_press, 1);
    check("short_t_rel", t_rel, 4);
    check("short_n_rel", n_rel, 1);
    check("short_t_short", t_short, 9);
    check("short_n_short", n_short, 1);
    check("short_long_dbl", n_long + n_dbl, 0);

    // Long press: hold 20 cycles
    clr();
    ticks(1'b0, 20);
    ticks(1'b1, 10);
    check("long_t_press", t_press, 1);
    check("long_t_long", t_long, 9);
    check("long_n_long", n_long, 1);
    check("long_held_first", t_held_first, 9);
    check("long_held_last", t_held_last, 20);
    check("long_n_held", n_held, 12);
    check("long_t_rel", t_rel, 21);
    check("long_no_short", n_short + n_dbl, 0);

    // Double click: press 2, release 2, press 20
    clr();
    ticks(1'b0, 2);
    ticks(1'b1, 2);
    ticks(1'b0, 20);
    ticks(1'b1, 10);
    check("dbl_n_press", n_press, 2);
    check("dbl_t_press", t_press, 5);
    check("dbl_t_dbl", t_dbl, 5);
    check("dbl_n_dbl", n_dbl, 1);
    check("dbl_no_long_short", n_long + n_short, 0);
    check("dbl_n_rel", n_rel, 2);
    check("dbl_t_rel", t_rel, 25);

    // Boundary: release exactly on the long threshold edge
    clr();
    ticks(1'b0, 8);
    ticks(1'b1, 10);
    check("bnd_long_n_long", n_long, 0);
    check("bnd_long_held", n_held, 0);
    check("bnd_long_t_rel", t_rel, 9);
    check("bnd_long_t_short", t_short, 14);

    // Boundary: second press exactly on the gap timeout edge
    clr();
    ticks(1'b0, 2);
    ticks(1'b1, 5);
    ticks(1'b0, 1);
    ticks(1'b1, 10);
    check("bnd_gap_t_dbl", t_dbl, 8);
    check("bnd_gap_n_short", n_short, 0);
    check("bnd_gap_t_rel", t_rel, 9);

    // Reset during GAP: pending short click dropped
    clr();
    ticks(1'b0, 2);
    ticks(1'b1, 3);
    rst_i = 1'b1;
    tick(1'b1);
    rst_i = 1'b0;
    ticks(1'b1, 12);
    check("rst_gap_n_short", n_short, 0);
    check("rst_gap_n_rel", n_rel, 1);

    // Normal press after the mid-operation reset
    clr();
    ticks(1'b0, 2);
    ticks(1'b1, 8);
    check("post_rst_t_press", t_press, 1);
    check("post_rst_t_short", t_short, 8);

    check("one_class_per_cycle", n_multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
